// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM/PWM bitstream CIC decoder.
//   CIC_ORDER : number of integrator/comb stages
//   PCM_FULL  : full-scale unsigned PCM code (all-high input)
//   cic_w()   : internal CIC word width for a given log2 decimation ratio
//   cic_state_e : comb pipeline sequencing states
package pdm_pkg;

   localparam int unsigned CIC_ORDER = 3;
   localparam logic [15:0] PCM_FULL  = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_C1,
      ST_C2,
      ST_C3
   } cic_state_e;

   // Bit growth of an order-N CIC is N*log2(R); one extra bit holds the
   // exact full-scale value R^N without aliasing it to zero.
   function automatic int unsigned cic_w(input int unsigned log2r);
      return CIC_ORDER * log2r + 1;
   endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: acc accumulates 'in' modulo 2^W on enabled clocks.
//   clk, rst : clock, synchronous active-high reset
//   en       : accumulate enable
//   in       : value added (previous stage's pre-update accumulator)
//   acc      : accumulator, wraps silently
module cic_integrator #(
   parameter int unsigned W = 31
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] in,
   output logic [W-1:0] acc
);

   // Wrap-around is intentional; the comb differences undo it.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + in;
      end
   end

endmodule

// File: rtl/pdm_cic_decoder.sv
// 1-bit PDM/PWM bitstream to 16-bit unsigned PCM, 3rd-order CIC decimator,
// ratio R = 2^DECIM_LOG2.
//   clk, rst   : clock, synchronous active-high reset
//   cen        : input sample enable (din sampled only when high)
//   din        : synchronised bitstream
//   dout       : decoded PCM, 0x0000 all-low .. 0xFFFF all-high
//   dout_valid : one-clock pulse when dout updates
//   settled    : sticky high once the comb delay line holds real history
module pdm_cic_decoder
   import pdm_pkg::*;
#(
   parameter int unsigned DECIM_LOG2 = 10,
   parameter int unsigned OUT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             din,
   output logic [OUT_W-1:0] dout,
   output logic             dout_valid,
   output logic             settled
);

   localparam int unsigned W     = cic_w(DECIM_LOG2);
   localparam int unsigned YW    = W - 1;
   localparam int unsigned SHIFT = YW - OUT_W;
   localparam logic [W-1:0] Y_FULL = {1'b1, {YW{1'b0}}};

   logic [DECIM_LOG2-1:0] dcnt_q;
   logic [W-1:0]          i1, i2, i3;
   logic [W-1:0]          x0_q, c1_q, c2_q;
   logic [W-1:0]          d1_q, d2_q, d3_q;
   logic [1:0]            warm_q;
   cic_state_e            state_q, state_d;

   logic                  dec_event_c;
   logic                  ld_x0_c, ld_c1_c, ld_c2_c, fin_c;
   logic [W-1:0]          y_c;
   logic [OUT_W-1:0]      pcm_c;

   // Integrator chain; each stage sees the previous stage's pre-update value.
   cic_integrator #(.W(W)) u_int1 (
      .clk (clk), .rst (rst), .en (cen), .in (W'(din)), .acc (i1)
   );
   cic_integrator #(.W(W)) u_int2 (
      .clk (clk), .rst (rst), .en (cen), .in (i1), .acc (i2)
   );
   cic_integrator #(.W(W)) u_int3 (
      .clk (clk), .rst (rst), .en (cen), .in (i2), .acc (i3)
   );

   // Decimation counter: event on the R-th enabled sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         dcnt_q <= '0;
      end else if (cen) begin
         dcnt_q <= dcnt_q + DECIM_LOG2'(1);
      end
   end

   assign dec_event_c = cen && (dcnt_q == '1);

   // Comb sequencer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, stage strobes and output scaling.
   always_comb begin
      state_d = state_q;
      ld_x0_c = 1'b0;
      ld_c1_c = 1'b0;
      ld_c2_c = 1'b0;
      fin_c   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (dec_event_c) begin
               ld_x0_c = 1'b1;
               state_d = ST_C1;
            end
         end
         ST_C1: begin
            ld_c1_c = 1'b1;
            state_d = ST_C2;
         end
         ST_C2: begin
            ld_c2_c = 1'b1;
            state_d = ST_C3;
         end
         ST_C3: begin
            fin_c   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      y_c   = c2_q - d3_q;
      // Only the exact full-scale value carries into the top bit.
      pcm_c = (y_c == Y_FULL) ? PCM_FULL : OUT_W'(y_c >> SHIFT);
   end

   // Comb stages, warm-up tracking and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         x0_q       <= '0;
         c1_q       <= '0;
         c2_q       <= '0;
         d1_q       <= '0;
         d2_q       <= '0;
         d3_q       <= '0;
         warm_q     <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         settled    <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         if (ld_x0_c) begin
            // I3 as it will be after this cycle's update.
            x0_q <= i3 + i2;
         end
         if (ld_c1_c) begin
            c1_q <= x0_q - d1_q;
            d1_q <= x0_q;
         end
         if (ld_c2_c) begin
            c2_q <= c1_q - d2_q;
            d2_q <= c1_q;
         end
         if (fin_c) begin
            d3_q <= c2_q;
            // First three passes only fill the comb delays.
            if (warm_q == 2'd3) begin
               dout       <= pcm_c;
               dout_valid <= 1'b1;
               settled    <= 1'b1;
            end else begin
               warm_q <= warm_q + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pdm_cic_decoder.sv
// Self-checking bench for pdm_cic_decoder: a convolution-kernel model of the
// CIC predicts every output, plus literal expectations for known patterns.
module tb_pdm_cic_decoder;
   import pdm_pkg::*;

   localparam int unsigned DECIM_LOG2 = 10;
   localparam int          R          = 1 << DECIM_LOG2;
   localparam int          YB         = 3 * DECIM_LOG2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b0;
   logic        din = 1'b0;
   logic [15:0] dout;
   logic        dout_valid;
   logic        settled;

   int n_checks = 0;
   int n_fail   = 0;

   pdm_cic_decoder #(.DECIM_LOG2(DECIM_LOG2), .OUT_W(16)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .settled    (settled)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      longint      due;
      logic [15:0] val;
   } pend_t;

   bit     hist[$];
   pend_t  pend[$];
   longint cyc    = 0;
   longint ones   = 0;
   int     passes = 0;
   logic        m_valid   = 1'b0;
   logic [15:0] m_dout    = 16'h0;
   logic        m_settled = 1'b0;

   function automatic longint c2(input longint m);
      return (m < 2) ? 0 : (m * (m - 1)) / 2;
   endfunction

   // Impulse response of three cascaded length-R moving sums, sampled at R.
   function automatic longint kern(input longint m);
      return c2(m) - 3 * c2(m - R) + 3 * c2(m - 2 * R) - c2(m - 3 * R);
   endfunction

   function automatic logic [15:0] model_dout();
      longint y = 0;
      int n = hist.size();
      for (int m = 0; m < 3 * R && m < n; m++)
         if (hist[n - 1 - m]) y += kern(m);
      if (y == (longint'(1) << YB)) return 16'hFFFF;
      return 16'((y >> (YB - 16)) & 16'hFFFF);
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         hist.delete();
         pend.delete();
         ones      = 0;
         passes    = 0;
         m_valid   = 1'b0;
         m_dout    = 16'h0;
         m_settled = 1'b0;
      end else begin
         m_valid = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            passes++;
            if (passes >= 4) begin
               m_valid   = 1'b1;
               m_dout    = pend[0].val;
               m_settled = 1'b1;
            end
            void'(pend.pop_front());
         end
         if (cen) begin
            hist.push_back(din);
            if (din) ones++;
            if (hist.size() % R == 0)
               pend.push_back('{due: cyc + 3, val: model_dout()});
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      check("dout_valid", longint'(dout_valid), longint'(m_valid));
      check("dout", longint'(dout), longint'(m_dout));
      check("settled", longint'(settled), longint'(m_settled));
      check("i1_probe", longint'(u_dut.i1), ones & ((longint'(1) << (YB + 1)) - 1));
   end

   // ---------------- stimulus ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cen = 1'b0;
      din = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // mode: 0 din=1, 1 din=0, 2 pattern 10, 3 pattern 1000,
   //       4 din=1 with cen every 3rd clk, 5 random din/cen
   task automatic run_mode(input int mode, input int events, input bit stop_at_c2);
      int  k = 0, pidx = 0, first = -1, prev = -1, tail = 0;
      int  budget = events * R * 4 + 64;
      bit  done = 1'b0;
      bit  c, d;
      logic [15:0] lit;
      lit = (mode == 1) ? 16'h0000 : (mode == 2) ? 16'h8000 :
            (mode == 3) ? 16'h4000 : 16'hFFFF;
      for (int rel = 1; rel <= budget && !done; rel++) begin
         c = (mode == 4) ? (k % 3 == 0) : (mode == 5) ? ($urandom_range(0, 3) != 0) : 1'b1;
         case (mode)
            1:       d = 1'b0;
            2:       d = (pidx % 2 == 0);
            3:       d = (pidx % 4 == 0);
            5:       d = 1'($urandom_range(0, 1));
            default: d = 1'b1;
         endcase
         if (pidx >= events * R) c = 1'b0;
         cen = c;
         din = d;
         if (c) pidx++;
         k++;
         @(negedge clk);
         if (dout_valid) begin
            if (first < 0) first = rel;
            if (mode != 5) check("pattern_dout", longint'(dout), longint'(lit));
            check("settled_at_valid", longint'(settled), 1);
            if (mode == 4 && prev >= 0) check("valid_spacing", rel - prev, 3 * R);
            prev = rel;
         end
         if (pidx >= events * R) begin
            if (stop_at_c2 && u_dut.state_q == ST_C2) done = 1'b1;
            else if (!stop_at_c2 && ++tail > 5) done = 1'b1;
         end
      end
      if (!done) check("run_timeout", 0, 1);
      if (mode <= 3) check("first_valid_latency", first, 4 * R + 3);
      cen = 1'b0;
   endtask

   initial begin
      do_reset();
      check("reset_dout", longint'(dout), 0);
      check("reset_valid", longint'(dout_valid), 0);
      check("reset_settled", longint'(settled), 0);

      run_mode(0, 6, 1'b0);
      do_reset();
      run_mode(1, 5, 1'b0);
      do_reset();
      run_mode(2, 5, 1'b0);
      do_reset();
      run_mode(3, 5, 1'b0);
      do_reset();
      run_mode(4, 6, 1'b0);
      do_reset();
      run_mode(5, 6, 1'b0);

      // Abort the 5th pass with a one-clock reset while it sits in C2.
      do_reset();
      run_mode(0, 5, 1'b1);
      rst = 1'b1;
      cen = 1'b1;
      din = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_dout", longint'(dout), 0);
      check("abort_settled", longint'(settled), 0);
      check("abort_valid", longint'(dout_valid), 0);
      run_mode(0, 5, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
